udp_tx_framer: RTL and testbench

//  Upstream stage of udp_receiver: accepts a 64-bit payload stream, buffers one frame, builds the 64-bit UDP header
//  {src_port,dst_port,length,checksum} and emits header word then payload words on a 64-bit valid/ready output.

---
 rtl/udp_tx_framer.sv | 156 +++++++++++++++
 tb/tb_udp_tx_framer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_framer.sv
// udp_tx_framer: buffers one payload frame, then emits the UDP header word
// {src_port, dst_port, length, checksum} followed by the buffered payload words.
// Optional feature macro: UDP_TX_CHECKSUM_EN (defined: one's-complement checksum;
// undefined: checksum field sent as 0x0000, same state sequence and timing).
`timescale 1ns/1ps

module udp_tx_framer #(
    parameter int MAX_WORDS = 16,
    parameter int LEN_W     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic        trunc_err
);

    localparam int AW = $clog2(MAX_WORDS);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FOLD1, S_FOLD2, S_HDR, S_DATA
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     src_q, dst_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   rd_q;
    logic            trunc_q;
    logic [63:0]     mem_q [MAX_WORDS];

    logic            accept;
    logic            wr_full;
    logic            last_rd;
    logic [CW-1:0]   last_idx;
    logic [LEN_W-1:0] len_w;
    logic [15:0]     chk_w;

    assign accept   = (state_q == S_LOAD) && in_valid;
    assign wr_full  = (cnt_q == LAST_IDX);
    assign last_idx = cnt_q - CW'(1);
    assign last_rd  = ({1'b0, rd_q} == last_idx);
    assign len_w    = LEN_W'(8) + (LEN_W'(cnt_q) << 3);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (accept && (in_last || wr_full)) state_d = S_FOLD1;
            S_FOLD1: state_d = S_FOLD2;
            S_FOLD2: state_d = S_HDR;
            S_HDR:   if (out_ready) state_d = S_DATA;
            S_DATA:  if (out_ready && last_rd) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; out_* depend only on held state so they stay stable while stalled
    always_comb begin
        in_ready  = (state_q == S_LOAD);
        busy      = (state_q != S_IDLE);
        trunc_err = trunc_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state_q)
            S_HDR: begin
                out_valid = 1'b1;
                out_data  = {src_q, dst_q, len_w, chk_w};
            end
            S_DATA: begin
                out_valid = 1'b1;
                out_data  = mem_q[rd_q];
                out_last  = last_rd;
            end
            default: ;
        endcase
    end

    // Frame control registers: ports, word count, read pointer, truncation pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            trunc_q <= 1'b0;
        end else begin
            trunc_q <= accept && !in_last && wr_full;
            if (state_q == S_IDLE && start) begin
                src_q <= src_port;
                dst_q <= dst_port;
                cnt_q <= '0;
                rd_q  <= '0;
            end
            if (accept) cnt_q <= cnt_q + CW'(1);
            if (state_q == S_DATA && out_ready && !last_rd) rd_q <= rd_q + AW'(1);
        end
    end

    // Payload buffer write
    always_ff @(posedge clk) begin
        if (accept) mem_q[cnt_q[AW-1:0]] <= in_data;
    end

`ifdef UDP_TX_CHECKSUM_EN
    logic [31:0] acc_q, acc_d;
    logic [31:0] fold_t;
    logic [15:0] inv_w;

    // Checksum accumulator: lane sums in LOAD, header fields + folds afterwards
    always_comb begin
        acc_d  = acc_q;
        fold_t = acc_q + {16'h0, src_q} + {16'h0, dst_q} + 32'(len_w);
        case (state_q)
            S_IDLE:  if (start) acc_d = '0;
            S_LOAD:  if (accept) acc_d = acc_q + {16'h0, in_data[15:0]}  + {16'h0, in_data[31:16]}
                                               + {16'h0, in_data[47:32]} + {16'h0, in_data[63:48]};
            S_FOLD1: acc_d = {16'h0, fold_t[15:0]} + {16'h0, fold_t[31:16]};
            S_FOLD2: acc_d = {16'h0, acc_q[15:0]} + {31'h0, acc_q[16]};
            default: ;
        endcase
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
    end

    // A computed checksum of zero is transmitted as 0xFFFF
    assign inv_w = ~acc_q[15:0];
    assign chk_w = (inv_w == 16'h0000) ? 16'hFFFF : inv_w;
`else
    assign chk_w = '0;
`endif

endmodule

// File: tb/tb_udp_tx_framer.sv
// tb_udp_tx_framer: randomized frames checked against a header/payload model.
`timescale 1ns/1ps

module tb_udp_tx_framer;

    localparam int MAXW = 16;
`ifdef UDP_TX_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk, rst, start, in_valid, in_last, in_ready;
    logic        out_valid, out_last, out_ready, busy, trunc_err;
    logic [15:0] src_port, dst_port;
    logic [63:0] in_data, out_data;

    udp_tx_framer #(.MAX_WORDS(MAXW), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .src_port(src_port), .dst_port(dst_port),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .trunc_err(trunc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int trunc_total = 0;
    logic [63:0] pl[$];
    logic [63:0] last_hdr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (trunc_err === 1'b1) trunc_total++;

    // Header from the rules: length = 8+8*words, one's-complement sum with folding
    function automatic logic [63:0] model_hdr(input logic [15:0] s, input logic [15:0] d, input int nw);
        int unsigned sum;
        logic [15:0] len, chk;
        logic [63:0] w;
        len = 16'(8 + 8 * nw);
        sum = 32'(s) + 32'(d) + 32'(len);
        for (int i = 0; i < nw; i++) begin
            w = pl[i];
            for (int l = 0; l < 4; l++) sum += 32'(w[16*l +: 16]);
        end
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        chk = ~sum[15:0];
        if (chk == 16'h0000) chk = 16'hFFFF;
        if (!CK_EN) chk = 16'h0000;
        return {s, d, len, chk};
    endfunction

    function automatic logic [63:0] cfg_hdr(input logic [63:0] full);
        return CK_EN ? full : {full[63:16], 16'h0000};
    endfunction

    task automatic fill_random(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back({$urandom, $urandom});
    endtask

    task automatic run_frame(input string tag, input logic [15:0] s, input logic [15:0] d,
                             input int n, input bit use_last, input int rdy_pct, input int abort_after);
        int exp_acc, tr0, hs;
        logic [63:0] got[$];
        bit gotl[$];
        bit held, done;
        logic [63:0] hd, exp_hdr;
        logic hl;
        exp_acc = (use_last || n < MAXW) ? n : MAXW;
        exp_hdr = model_hdr(s, d, exp_acc);
        tr0 = trunc_total;
        hs = 0; held = 0; done = 0; hd = '0; hl = 0;
        for (int w = 0; w < 50 && busy; w++) @(negedge clk);
        check_val({tag, "_idle"}, 64'(busy), 64'(0));
        @(posedge clk); #1;
        start = 1'b1; src_port = s; dst_port = d;
        @(posedge clk); #1;
        start = 1'b0; src_port = 16'($urandom); dst_port = 16'($urandom);
        for (int i = 0; i < exp_acc; i++) begin
            in_valid = 1'b1; in_data = pl[i]; in_last = use_last && (i == n - 1);
            @(negedge clk);
            check_val({tag, "_in_ready"}, 64'(in_ready), 64'(1));
            @(posedge clk); #1;
        end
        if (n > exp_acc) begin
            in_valid = 1'b1; in_data = pl[exp_acc]; in_last = 1'b0;
        end else begin
            in_valid = 1'b0; in_last = 1'b0;
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val({tag, "_lat_valid"}, 64'(out_valid), 64'(k == 2));
            if (k == 0) begin
                check_val({tag, "_ready_drop"}, 64'(in_ready), 64'(0));
                check_val({tag, "_trunc"}, 64'(trunc_err), 64'(!use_last));
            end
            if (k < 2) begin @(posedge clk); #1; end
        end
        check_val({tag, "_hdr_first"}, out_data, exp_hdr);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(posedge clk); #1;
            if (abort_after >= 0 && hs == abort_after) begin
                rst = 1'b0;
                #1;
                check_val({tag, "_rst_vld"},  64'(out_valid), 64'(0));
                check_val({tag, "_rst_data"}, out_data, 64'(0));
                check_val({tag, "_rst_last"}, 64'(out_last), 64'(0));
                check_val({tag, "_rst_busy"}, 64'(busy), 64'(0));
                check_val({tag, "_rst_rdy"},  64'(in_ready), 64'(0));
                check_val({tag, "_rst_trn"},  64'(trunc_err), 64'(0));
                out_ready = 1'b0; in_valid = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b1;
                return;
            end
            out_ready = (abort_after >= 0) ? 1'b1 : ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            if (held) begin
                check_val({tag, "_stall_vld"},  64'(out_valid), 64'(1));
                check_val({tag, "_stall_data"}, out_data, hd);
                check_val({tag, "_stall_last"}, 64'(out_last), 64'(hl));
            end
            held = out_valid && !out_ready; hd = out_data; hl = out_last;
            if (out_valid && out_ready) begin
                got.push_back(out_data); gotl.push_back(out_last); hs++;
                if (out_last) done = 1'b1;
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val({tag, "_done"}, 64'(done), 64'(1));
        check_val({tag, "_nwords"}, 64'(got.size()), 64'(exp_acc + 1));
        for (int j = 0; j < got.size() && j <= exp_acc; j++) begin
            check_val({tag, "_word"}, got[j], (j == 0) ? exp_hdr : pl[j-1]);
            check_val({tag, "_last"}, 64'(gotl[j]), 64'(j == exp_acc));
        end
        last_hdr = (got.size() > 0) ? got[0] : '0;
        check_val({tag, "_end_busy"}, 64'(busy), 64'(0));
        check_val({tag, "_end_rdy"}, 64'(in_ready), 64'(0));
        check_val({tag, "_trunc_cnt"}, 64'(trunc_total - tr0), 64'(!use_last));
        in_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] hdr_c;
        rst = 1'b0; start = 1'b0; src_port = '0; dst_port = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready",  64'(in_ready),  64'(0));
        check_val("rst_out_valid", 64'(out_valid), 64'(0));
        check_val("rst_out_data",  out_data,       64'(0));
        check_val("rst_out_last",  64'(out_last),  64'(0));
        check_val("rst_busy",      64'(busy),      64'(0));
        check_val("rst_trunc",     64'(trunc_err), 64'(0));
        rst = 1'b1;

        pl.delete(); pl.push_back(64'h1);
        run_frame("T1", 16'h1234, 16'h5678, 1, 1'b1, 100, -1);
        hdr_c = 64'h1234_5678_0010_9742;
        check_val("T1_hdr", last_hdr, cfg_hdr(hdr_c));

        pl.delete(); pl.push_back(64'h0);
        run_frame("T2", 16'hFFFF, 16'h0001, 1, 1'b1, 100, -1);
        hdr_c = 64'hFFFF_0001_0010_FFEE;
        check_val("T2_hdr", last_hdr, cfg_hdr(hdr_c));

        pl.delete(); pl.push_back(64'h0);
        run_frame("T3", 16'hFFEF, 16'h0000, 1, 1'b1, 100, -1);
        hdr_c = 64'hFFEF_0000_0010_FFFF;
        check_val("T3_hdr", last_hdr, cfg_hdr(hdr_c));

        fill_random(MAXW + 2);
        run_frame("T4", 16'($urandom), 16'($urandom), MAXW + 2, 1'b0, 100, -1);
        hdr_c = last_hdr;
        check_val("T4_len", 64'(hdr_c[31:16]), 64'(8 + 8 * MAXW));

        fill_random(4);
        run_frame("T5", 16'($urandom), 16'($urandom), 4, 1'b1, 50, -1);

        fill_random(4);
        run_frame("T6a", 16'($urandom), 16'($urandom), 4, 1'b1, 100, 2);
        fill_random(3);
        run_frame("T6b", 16'hABCD, 16'h0042, 3, 1'b1, 100, -1);

        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(MAXW, 1);
            fill_random(n);
            run_frame("RND", 16'($urandom), 16'($urandom), n, 1'b1, $urandom_range(100, 30), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
